mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single von Neumann memory port between instruction fetch (IF) and
//  data access (MEM stage). Fixed data priority, with an anti-starvation limit for fetch.
//  Relocates data addresses by a programmable data-segment base.
//  Registers read data back to each requester.
// PARAMETERS
//  ADDR_W        8    memory address width (memory depth = 2**ADDR_W)
//  DATA_W        8    memory word width
//  MAX_STREAK    3    max consecutive data grants while fetch waits (1..2**CNT_W-1)
//  CNT_W         2    streak counter width
//  DATA_BASE_RST 128  reset value of data-segment base register
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  if_req     in   1       fetch request
//  if_addr    in   ADDR_W  fetch address (absolute)
//  if_gnt     out  1       fetch granted this cycle (combinational)
//  if_rvalid  out  1       if_rdata valid (registered pulse)
//  if_rdata   out  DATA_W  fetched instruction
//  d_req      in   1       data request
//  d_we       in   1       1=write, 0=read
//  d_addr     in   ADDR_W  data address (segment-relative)
//  d_wdata    in   DATA_W  write data
//  d_gnt      out  1       data granted this cycle (combinational)
//  d_rvalid   out  1       d_rdata valid (registered pulse, reads only)
//  d_rdata    out  DATA_W  read data
//  cfg_we     in   1       load data-segment base
//  cfg_base   in   ADDR_W  new base value
//  mem_addr   out  ADDR_W  shared memory address
//  mem_we     out  1       memory write enable
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data (combinational read of mem_addr)
// BEHAVIOUR
//  Reset (rst=0): base=DATA_BASE_RST, streak=0, last=NONE.
//   if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, mem_we forced 0 while rst=0.
//   Reset mid-transfer drops the pending rvalid.
//  Grant, cycle t:
//   - d_req and not (if_req and streak==MAX_STREAK): d_gnt=1.
//   - else if if_req: if_gnt=1.
//   - else neither. At most one gnt is ever high.
//  Memory port:
//   - Data grant: mem_addr = d_addr+base, truncated mod 2**ADDR_W (wraps);
//     mem_we = d_we; mem_wdata = d_wdata.
//   - Fetch grant: mem_addr = if_addr, mem_we = 0.
//   - Idle: mem_addr = 0, mem_we = 0.
//  Read latency 1: mem_rdata sampled at end of grant cycle t.
//   - xx_rdata and xx_rvalid=1 appear in t+1; rvalid is a 1-cycle pulse.
//   - A write produces no d_rvalid.
//   - Non-granted side's rdata holds its last value.
//  Handshake: requester holds req/addr/wdata until the gnt cycle.
//   May issue a new request the cycle after gnt (back-to-back allowed).
//  Streak counter:
//   - +1 on each d_gnt while if_req=1, saturating at MAX_STREAK.
//   - Cleared on if_gnt, or on any cycle with if_req=0.
//  State last∈{NONE,IF,D} records the previous grantee and steers rvalid routing.
//  Simultaneous events:
//   - cfg_we with a data access: the access uses the OLD base; the new base applies from t+1.
//   - Data write and fetch to the same address: data wins; the fetch is granted later and reads the new value.
// STRUCTURE
//  Package mem_arb_pkg: grantee enum {GNT_NONE,GNT_IF,GNT_D}, DATA_BASE_RST, MAX_STREAK defaults.
//  Sub-module arb_streak_counter (saturating CNT_W counter with inc/clr/sat flag).
//  Remainder (grant logic, base register, response registers) stays in this module.
// TESTING
//  1 Reset: hold rst=0 with d_req=1, d_we=1 -> mem_we=0, all rvalid=0. Release: base=128.
//  2 Data read d_addr=5, base=128, mem[133]=8'hA5 -> d_gnt same cycle, mem_addr=133; d_rvalid=1, d_rdata=A5 next cycle.
//  3 Contention: if_req and d_req held 6 cycles, MAX_STREAK=3 -> grants D,D,D,IF,D,D.
//    Streak counter clears after the IF grant.
//  4 Wrap: cfg_base=200 then d_addr=100 -> mem_addr=44.
//    cfg_we in the same cycle as the access -> the old base is used.
//  5 Data write to 130 plus fetch of 130 in the same cycle (base=0) -> write is granted first.
//    Fetch is granted the next cycle and if_rdata = new value.
//  6 rst pulsed low while a read is granted -> no rvalid after release; the next read completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the von Neumann memory port arbiter.
// Grantee encoding plus reset/priority defaults.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grantee_e;

    localparam int DATA_BASE_RST_DEF = 128;
    localparam int MAX_STREAK_DEF    = 3;
    localparam int CNT_W_DEF         = 2;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating counter of consecutive data grants taken while fetch waits.
// Clear has priority over increment; sat flags the fetch-must-win point.
module arb_streak_counter #(
    parameter int CNT_W = 2,
    parameter int MAX   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] cnt;

    assign sat = (cnt == CNT_W'(MAX));

    // count data grants, hold at MAX, drop to zero when fetch is served or idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data, data first with a fetch
// starvation limit; relocates data by a segment base; registers read data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int MAX_STREAK    = MAX_STREAK_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int DATA_BASE_RST = DATA_BASE_RST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W-1:0] base;
    logic              streak_sat;
    grantee_e          last;
    logic              last_rd;

    arb_streak_counter #(
        .CNT_W (CNT_W),
        .MAX   (MAX_STREAK)
    ) u_streak (
        .clk (clk),
        .rst (rst),
        .inc (d_gnt && if_req),
        .clr (if_gnt || !if_req),
        .sat (streak_sat)
    );

    // data wins unless fetch has waited through MAX_STREAK data grants
    always_comb begin
        d_gnt  = d_req && !(if_req && streak_sat);
        if_gnt = if_req && !d_gnt;
    end

    // steer the shared port; writes are suppressed while reset is held
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = d_wdata;
        unique case (1'b1)
            d_gnt: begin
                mem_addr = d_addr + base;
                mem_we   = d_we && rst;
            end
            if_gnt: begin
                mem_addr = if_addr;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    // segment base: an access in the load cycle still sees the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= ADDR_W'(DATA_BASE_RST);
        end else if (cfg_we) begin
            base <= cfg_base;
        end
    end

    // capture the grantee and its read data for the following cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last     <= GNT_NONE;
            last_rd  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            last    <= d_gnt ? GNT_D : (if_gnt ? GNT_IF : GNT_NONE);
            last_rd <= d_gnt && !d_we;
            if (if_gnt) begin
                if_rdata <= mem_rdata;
            end
            if (d_gnt && !d_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign if_rvalid = (last == GNT_IF);
    assign d_rvalid  = (last == GNT_D) && last_rd;

endmodule
